// File: rtl/produce_sensor_qualifier_if.sv
// Sample/flag handshake bundle for produce_sensor_qualifier.
// slave = qualifier side, master = sensor front-end / grader side.
interface produce_sensor_qualifier_if #(
  parameter int unsigned DATA_W = 8
);
  logic              sample_valid_i;
  logic [DATA_W-1:0] weight_raw_i;
  logic [DATA_W-1:0] size_raw_i;
  logic [DATA_W-1:0] color_raw_i;
  logic              flags_ready_i;
  logic              flags_valid_o;
  logic              weight_ok_o;
  logic              size_ok_o;
  logic              color_ok_o;

  modport master (
    output sample_valid_i, weight_raw_i, size_raw_i, color_raw_i, flags_ready_i,
    input  flags_valid_o, weight_ok_o, size_ok_o, color_ok_o
  );

  modport slave (
    input  sample_valid_i, weight_raw_i, size_raw_i, color_raw_i, flags_ready_i,
    output flags_valid_o, weight_ok_o, size_ok_o, color_ok_o
  );
endinterface

// File: rtl/produce_sensor_qualifier.sv
// Averages a burst of 2^AVG_LOG2 weight/size/colour samples and presents threshold
// flags through a valid/ready handshake. Optional ITEM_COUNT_EN adds item_count_o.
module produce_sensor_qualifier #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned WEIGHT_MIN = 100,
  parameter int unsigned WEIGHT_MAX = 200,
  parameter int unsigned SIZE_MIN   = 50,
  parameter int unsigned COLOR_MIN  = 128,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  produce_sensor_qualifier_if.slave    bus,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         timeout_o
`ifdef ITEM_COUNT_EN
  ,
  output logic [15:0]                  item_count_o
`endif
);

  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  BURST_LEN = CNT_W'(1) << AVG_LOG2;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] W_MIN     = DATA_W'(WEIGHT_MIN);
  localparam logic [DATA_W-1:0] W_MAX     = DATA_W'(WEIGHT_MAX);
  localparam logic [DATA_W-1:0] S_MIN     = DATA_W'(SIZE_MIN);
  localparam logic [DATA_W-1:0] C_MIN     = DATA_W'(COLOR_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    weight_sum_q, weight_sum_d;
  logic [SUM_W-1:0]    size_sum_q, size_sum_d;
  logic [SUM_W-1:0]    color_sum_q, color_sum_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                flags_valid_q, flags_valid_d;
  logic                weight_ok_q, weight_ok_d;
  logic                size_ok_q, size_ok_d;
  logic                color_ok_q, color_ok_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
`ifdef ITEM_COUNT_EN
  logic [15:0]         item_count_q, item_count_d;
`endif

  // Truncating average: the top DATA_W bits of each accumulator.
  logic [DATA_W-1:0] weight_avg, size_avg, color_avg;
  assign weight_avg = weight_sum_q[SUM_W-1:AVG_LOG2];
  assign size_avg   = size_sum_q[SUM_W-1:AVG_LOG2];
  assign color_avg  = color_sum_q[SUM_W-1:AVG_LOG2];

  always_comb begin
    state_d       = state_q;
    weight_sum_d  = weight_sum_q;
    size_sum_d    = size_sum_q;
    color_sum_d   = color_sum_q;
    count_d       = count_q;
    idle_cnt_d    = idle_cnt_q;
    flags_valid_d = flags_valid_q;
    weight_ok_d   = weight_ok_q;
    size_ok_d     = size_ok_q;
    color_ok_d    = color_ok_q;
    overrun_d     = overrun_q;
    timeout_d     = 1'b0;
`ifdef ITEM_COUNT_EN
    item_count_d  = item_count_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.sample_valid_i) begin
          weight_sum_d = SUM_W'(bus.weight_raw_i);
          size_sum_d   = SUM_W'(bus.size_raw_i);
          color_sum_d  = SUM_W'(bus.color_raw_i);
          count_d      = CNT_W'(1);
          idle_cnt_d   = '0;
          state_d      = (BURST_LEN == CNT_W'(1)) ? S_COMPARE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.sample_valid_i) begin
          weight_sum_d = weight_sum_q + SUM_W'(bus.weight_raw_i);
          size_sum_d   = size_sum_q + SUM_W'(bus.size_raw_i);
          color_sum_d  = color_sum_q + SUM_W'(bus.color_raw_i);
          count_d      = count_q + CNT_W'(1);
          idle_cnt_d   = '0;
          if (count_d == BURST_LEN) state_d = S_COMPARE;
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Abandon the partial burst; flags from the last item are kept.
          timeout_d    = 1'b1;
          weight_sum_d = '0;
          size_sum_d   = '0;
          color_sum_d  = '0;
          count_d      = '0;
          idle_cnt_d   = '0;
          state_d      = S_IDLE;
        end else begin
          idle_cnt_d   = idle_cnt_q + IDLE_W'(1);
        end
      end
      S_COMPARE: begin
        weight_ok_d   = (weight_avg >= W_MIN) && (weight_avg <= W_MAX);
        size_ok_d     = (size_avg >= S_MIN);
        color_ok_d    = (color_avg >= C_MIN);
        flags_valid_d = 1'b1;
        state_d       = S_HOLD;
        if (bus.sample_valid_i) overrun_d = 1'b1;
      end
      S_HOLD: begin
        if (bus.sample_valid_i) overrun_d = 1'b1;
        if (bus.flags_ready_i) begin
          flags_valid_d = 1'b0;
          count_d       = '0;
          state_d       = S_IDLE;
`ifdef ITEM_COUNT_EN
          item_count_d  = item_count_q + 16'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      weight_sum_q  <= '0;
      size_sum_q    <= '0;
      color_sum_q   <= '0;
      count_q       <= '0;
      idle_cnt_q    <= '0;
      flags_valid_q <= 1'b0;
      weight_ok_q   <= 1'b0;
      size_ok_q     <= 1'b0;
      color_ok_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef ITEM_COUNT_EN
      item_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      weight_sum_q  <= weight_sum_d;
      size_sum_q    <= size_sum_d;
      color_sum_q   <= color_sum_d;
      count_q       <= count_d;
      idle_cnt_q    <= idle_cnt_d;
      flags_valid_q <= flags_valid_d;
      weight_ok_q   <= weight_ok_d;
      size_ok_q     <= size_ok_d;
      color_ok_q    <= color_ok_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
`ifdef ITEM_COUNT_EN
      item_count_q  <= item_count_d;
`endif
    end
  end

  assign bus.flags_valid_o = flags_valid_q;
  assign bus.weight_ok_o   = weight_ok_q;
  assign bus.size_ok_o     = size_ok_q;
  assign bus.color_ok_o    = color_ok_q;
  assign busy_o            = busy_q;
  assign overrun_o         = overrun_q;
  assign timeout_o         = timeout_q;
`ifdef ITEM_COUNT_EN
  assign item_count_o      = item_count_q;
`endif

endmodule

// File: tb/tb_produce_sensor_qualifier.sv
// Scoreboard bench for produce_sensor_qualifier: directed bursts push expected flags,
// a negedge monitor pops them when flags_valid_o rises and checks latency/stability.
module tb_produce_sensor_qualifier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  produce_sensor_qualifier_if #(.DATA_W(8)) bus ();
  logic busy_o, overrun_o, timeout_o;
`ifdef ITEM_COUNT_EN
  logic [15:0] item_count_o;
`endif

  produce_sensor_qualifier #(
    .DATA_W(8), .AVG_LOG2(2), .WEIGHT_MIN(100), .WEIGHT_MAX(200),
    .SIZE_MIN(50), .COLOR_MIN(128), .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy_o    (busy_o),
    .overrun_o (overrun_o),
    .timeout_o (timeout_o)
`ifdef ITEM_COUNT_EN
    ,
    .item_count_o (item_count_o)
`endif
  );

  typedef struct {
    logic        w;
    logic        s;
    logic        c;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_hs     = 0;
  logic [2:0]  last_flags = 3'b000;
  logic [2:0]  held       = 3'b000;
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each fresh flags_valid_o.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      n_hs       = 0;
    end else begin
      if (prev_hs) check("valid_drop_after_hs", bus.flags_valid_o, 0);
      if (bus.flags_valid_o && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("flag_weight", bus.weight_ok_o, mon_e.w);
          check("flag_size", bus.size_ok_o, mon_e.s);
          check("flag_color", bus.color_ok_o, mon_e.c);
          check("latency", cyc, mon_e.cyc);
        end
        held = {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o};
      end else if (bus.flags_valid_o) begin
        check("flags_stable", {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o}, held);
      end
      if (bus.flags_valid_o && bus.flags_ready_i) n_hs++;
      prev_valid = bus.flags_valid_o;
      prev_hs    = bus.flags_valid_o && bus.flags_ready_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] w, input logic [7:0] s, input logic [7:0] c);
    bus.sample_valid_i = v;
    bus.weight_raw_i   = w;
    bus.size_raw_i     = s;
    bus.color_raw_i    = c;
  endtask

  task automatic burst4(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] w3, input logic [7:0] s, input logic [7:0] c,
                        input logic ew, input logic es, input logic ec);
    logic [7:0] wv[4];
    exp_t e;
    wv = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, wv[i], s, c);
      if (i == 3) begin
        e.w = ew; e.s = es; e.c = ec; e.cyc = cyc + 2;
        sb.push_back(e);
      end
      tick();
    end
    set_in(1'b0, 8'd0, 8'd0, 8'd0);
    last_flags = {ew, es, ec};
  endtask

  task automatic wait_done(input string name);
    int unsigned k = 0;
    while ((busy_o || bus.flags_valid_o) && k < 30) begin
      tick();
      k++;
    end
    if (k >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: got busy expected idle within 30 cycles", name);
    end
    check({name, "_persist"}, {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o}, last_flags);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, bus.flags_valid_o, 0);
    check({name, "_flags"}, {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o}, 0);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_overrun"}, overrun_o, 0);
    check({name, "_timeout"}, timeout_o, 0);
  endtask

  initial begin
    int unsigned pulses;
    int unsigned pulse_at;
    int unsigned k;

    rst = 1'b1;
    bus.flags_ready_i = 1'b1;
    set_in(1'b0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal burst and threshold boundaries.
    burst4(8'd150, 8'd150, 8'd150, 8'd150, 8'd60, 8'd200, 1'b1, 1'b1, 1'b1);
    wait_done("nominal");
    check("nominal_busy", busy_o, 0);
    check("nominal_overrun", overrun_o, 0);
    burst4(8'd199, 8'd200, 8'd201, 8'd200, 8'd60, 8'd200, 1'b1, 1'b1, 1'b1);
    wait_done("wmax_incl");
    burst4(8'd201, 8'd201, 8'd201, 8'd201, 8'd60, 8'd200, 1'b0, 1'b1, 1'b1);
    wait_done("wmax_excl");
    burst4(8'd99, 8'd100, 8'd100, 8'd100, 8'd60, 8'd200, 1'b0, 1'b1, 1'b1);
    wait_done("wmin_trunc");
    burst4(8'd150, 8'd150, 8'd150, 8'd150, 8'd49, 8'd128, 1'b1, 1'b0, 1'b1);
    wait_done("size49_col128");
    burst4(8'd150, 8'd150, 8'd150, 8'd150, 8'd50, 8'd127, 1'b1, 1'b1, 1'b0);
    wait_done("size50_col127");

    // Grader stalls in HOLD while samples keep arriving.
    bus.flags_ready_i = 1'b0;
    burst4(8'd150, 8'd150, 8'd150, 8'd150, 8'd60, 8'd200, 1'b1, 1'b1, 1'b1);
    k = 0;
    while (!bus.flags_valid_o && k < 10) begin
      tick();
      k++;
    end
    check("hold_reached", bus.flags_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'd0, 8'd0, 8'd0);
      tick();
    end
    check("overrun_set", overrun_o, 1);
    check("hold_still_valid", bus.flags_valid_o, 1);
    set_in(1'b0, 8'd0, 8'd0, 8'd0);
    bus.flags_ready_i = 1'b1;
    tick();
    check("hold_release_valid", bus.flags_valid_o, 0);
    check("hold_release_busy", busy_o, 0);
    burst4(8'd150, 8'd150, 8'd150, 8'd150, 8'd60, 8'd100, 1'b1, 1'b1, 1'b0);
    wait_done("post_overrun");
    check("overrun_sticky", overrun_o, 1);

    // Partial burst abandoned by timeout.
    set_in(1'b1, 8'd10, 8'd10, 8'd10);
    tick();
    tick();
    set_in(1'b0, 8'd0, 8'd0, 8'd0);
    pulses = 0;
    pulse_at = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (timeout_o) begin
        pulses++;
        pulse_at = t;
      end
      if (t == 15) check("timeout_busy_before", busy_o, 1);
    end
    check("timeout_pulses", pulses, 1);
    check("timeout_cycle", pulse_at, 16);
    check("timeout_busy_after", busy_o, 0);
    check("timeout_valid", bus.flags_valid_o, 0);
    check("timeout_flags_kept", {bus.weight_ok_o, bus.size_ok_o, bus.color_ok_o}, last_flags);
    burst4(8'd250, 8'd250, 8'd250, 8'd250, 8'd50, 8'd255, 1'b0, 1'b1, 1'b1);
    wait_done("post_timeout");

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'd250, 8'd10, 8'd10);
      tick();
    end
    set_in(1'b0, 8'd0, 8'd0, 8'd0);
    rst = 1'b1;
    tick();
    check_all_zero("midburst_rst");
    rst = 1'b0;
    last_flags = 3'b000;
    tick();
    burst4(8'd100, 8'd100, 8'd100, 8'd100, 8'd50, 8'd128, 1'b1, 1'b1, 1'b1);
    wait_done("post_rst");

`ifdef ITEM_COUNT_EN
    check("item_count", item_count_o, n_hs & 32'hFFFF);
`endif
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/produce_sensor_qualifier.md
Name: produce_sensor_qualifier

Overview:
Front-end for the produce quality grader. Accepts raw weight, size and colour sensor samples and averages a fixed-size burst of them. Compares the averages against threshold parameters and presents registered weight_ok/size_ok/color_ok flags. Flags are presented through a valid/ready handshake, so the grader always evaluates a stable, complete measurement.

Parameters:
DATA_W, 8, width of each raw sensor sample
AVG_LOG2, 2, log2 of samples averaged per item (default 4 samples)
WEIGHT_MIN, 100, minimum acceptable average weight (inclusive)
WEIGHT_MAX, 200, maximum acceptable average weight (inclusive)
SIZE_MIN, 50, minimum acceptable average size (inclusive)
COLOR_MIN, 128, minimum acceptable average colour (inclusive)
TIMEOUT, 16, idle cycles allowed between samples inside a burst

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sample_valid_i  in  1  one sample triple present this cycle
weight_raw_i  in  DATA_W  raw weight sample
size_raw_i  in  DATA_W  raw size sample
color_raw_i  in  DATA_W  raw colour sample
flags_ready_i  in  1  grader accepts current flags
flags_valid_o  out  1  flags are a fresh, complete measurement
weight_ok_o  out  1  weight within [WEIGHT_MIN, WEIGHT_MAX]
size_ok_o  out  1  size >= SIZE_MIN
color_ok_o  out  1  colour >= COLOR_MIN
busy_o  out  1  burst in progress (state != IDLE)
overrun_o  out  1  sticky: sample dropped while not accepting
timeout_o  out  1  one-cycle pulse: burst aborted by timeout

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. All state and outputs are registered.
- Reset state: IDLE. All outputs are 0. Accumulators, sample count and idle counter are 0.
- Accumulators are DATA_W+AVG_LOG2 bits wide, one per channel. Overflow is impossible by construction.
- Average = sum >> AVG_LOG2, truncating. Comparisons are unsigned.
- IDLE:
  - sample_valid_i loads the accumulators with the samples, count=1, idle counter cleared.
  - Next state is ACCUM, or COMPARE if AVG_LOG2=0.
- ACCUM:
  - sample_valid_i adds the samples, increments count and clears the idle counter.
  - When the accepted sample is number 2^AVG_LOG2, next state is COMPARE.
  - With no sample, the idle counter increments. When it reaches TIMEOUT: pulse timeout_o for 1 cycle, discard the partial sums, go to IDLE. Flag outputs are unchanged.
- COMPARE (1 cycle):
  - Register the three flags from the averages and set flags_valid_o.
  - Go to HOLD.
  - Latency: the last sample accepted at cycle k gives flags_valid_o=1 and new flags at cycle k+2.
- HOLD:
  - flags_valid_o=1 with flags stable.
  - flags_valid_o and flags_ready_i both high in a cycle completes the handshake. Next cycle: flags_valid_o=0, state IDLE.
  - flags_ready_i already high at the first HOLD cycle completes in that cycle.
- Flag values persist after the handshake until the next COMPARE overwrites them.
- Samples arriving in COMPARE or HOLD are dropped and set overrun_o. overrun_o clears only on rst.
- A sample in the same cycle as the handshake completes is dropped; IDLE accepts from the following cycle.
- Reset asserted in any state, including mid-burst or mid-HOLD, forces IDLE and clears everything the same cycle.

Optional Feature:
ITEM_COUNT_EN:
- Defined: adds output item_count_o [15:0]. Reset 0. Increments by 1 on every completed flags handshake and wraps 65535->0. Not incremented by timeouts.
- Undefined: port and counter absent, no other behaviour change.

Test Plan:
- Four samples (150,60,200) on consecutive cycles, flags_ready_i=1 -> flags_valid_o=1 exactly 2 cycles after the 4th sample, flags 1/1/1, valid drops the next cycle, busy_o=0.
- Weights 199,200,201,200 (sum 800, avg 200) -> weight_ok_o=1. Weights 201x4 -> 0. Weights 99,100,100,100 (avg 99, truncated) -> 0. Size 49x4 -> size_ok_o=0. Colour 128x4 -> color_ok_o=1.
- flags_ready_i held low 5 cycles in HOLD while sample_valid_i=1 -> flags stable, overrun_o=1 and stays 1. Ready high -> IDLE next cycle. The next burst is measured from fresh samples only.
- 2 samples then 16 idle cycles -> timeout_o pulses once, state IDLE, previous flags unchanged, flags_valid_o stays 0. A following 4-sample burst grades correctly.
- rst=1 after 3 samples of a burst -> next cycle all outputs 0. A new 4-sample burst grades with no carry-over from the partial sums.
- ITEM_COUNT_EN: 3 completed handshakes plus 1 timeout -> item_count_o=3. Preload-equivalent of 65535 handshakes plus 1 -> wraps to 0.
